// File: rtl/led_pattern_sequencer.sv
// Multi-channel serial LED pattern blinker driven by one shared step prescaler.
// Latency: led trails idx by one cycle; a load lands 1 cycle after accept (idle target) or on the next step tick (running target).
// Backpressure: one pending load slot; load_ready stays low from accept until the slot is applied or dropped.
module led_pattern_sequencer #(
    parameter int                CHANNELS        = 1,
    parameter int                PAT_W           = 32,
    parameter int                STEP_LOG2       = 21,
    parameter logic [PAT_W-1:0]  DEFAULT_PATTERN = 32'h0547_7715,
    parameter int                DEFAULT_LEN     = 27,
    localparam int               CH_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int               LEN_W           = $clog2(PAT_W + 1),
    localparam int               IDX_W           = $clog2(PAT_W)
) (
    input  logic                 CLK_CPU,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [CH_W-1:0]      load_channel,
    input  logic [PAT_W-1:0]     load_pattern,
    input  logic [LEN_W-1:0]     load_len,
    input  logic                 load_oneshot,
    output logic [CHANNELS-1:0]  led,
    output logic [CHANNELS-1:0]  busy,
    output logic [CHANNELS-1:0]  done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [STEP_LOG2-1:0] presc;
    logic                 tick;

    always_ff @(posedge CLK_CPU or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (enable) begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = enable & (&presc);

    logic                slot_full;
    logic [CH_W-1:0]     slot_ch;
    logic [PAT_W-1:0]    slot_pat;
    logic [LEN_W-1:0]    slot_len;
    logic                slot_os;
    logic [CHANNELS-1:0] apply;
    logic                slot_drop;
    logic                slot_free;
    logic [LEN_W-1:0]    len_clamped;

    assign len_clamped = (load_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : load_len;
    // Out-of-range channel numbers occupy the slot for one cycle and then vanish.
    assign slot_drop   = slot_full && (32'(slot_ch) >= CHANNELS);
    assign slot_free   = slot_drop | (|apply);
    assign load_ready  = ~slot_full;

    always_ff @(posedge CLK_CPU or posedge reset) begin
        if (reset) begin
            slot_full <= 1'b0;
            slot_ch   <= '0;
            slot_pat  <= '0;
            slot_len  <= '0;
            slot_os   <= 1'b0;
        end else if (slot_free) begin
            slot_full <= 1'b0;
        end else if (load_valid && !slot_full) begin
            slot_full <= 1'b1;
            slot_ch   <= load_channel;
            slot_pat  <= load_pattern;
            slot_len  <= len_clamped;
            slot_os   <= load_oneshot;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam logic [CH_W-1:0] CH_ID = CH_W'(c);

        state_t           state;
        logic [PAT_W-1:0] pattern;
        logic [LEN_W-1:0] len;
        logic             oneshot;
        logic [IDX_W-1:0] idx;
        logic             led_q;
        logic             done_q;
        logic             last;

        // A running channel only takes a new pattern on a step boundary.
        assign apply[c] = slot_full && (slot_ch == CH_ID) && ((state != ST_RUN) || tick);
        assign last     = (LEN_W'(idx) == len - 1'b1);

        always_ff @(posedge CLK_CPU or posedge reset) begin
            if (reset) begin
                state   <= ST_RUN;
                pattern <= DEFAULT_PATTERN;
                len     <= LEN_W'(DEFAULT_LEN);
                oneshot <= 1'b0;
                idx     <= '0;
                led_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                led_q  <= (state == ST_RUN) ? pattern[idx] : 1'b0;
                done_q <= 1'b0;
                if (apply[c]) begin
                    pattern <= slot_pat;
                    len     <= slot_len;
                    oneshot <= slot_os;
                    idx     <= '0;
                    state   <= (slot_len == '0) ? ST_IDLE : ST_RUN;
                end else if ((state == ST_RUN) && tick) begin
                    if (last) begin
                        idx <= '0;
                        if (oneshot) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
            end
        end

        assign led[c]  = led_q;
        assign done[c] = done_q;
        assign busy[c] = (state == ST_RUN);
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: queue-based behavioural model checked every cycle,
// plus directed loads with hand-computed timing for the step/handshake corner cases.
module tb_led_pattern_sequencer;

    localparam int NCH = 3;

    logic        CLK_CPU = 1'b0;
    logic        reset   = 1'b0;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [1:0]  load_channel;
    logic [31:0] load_pattern;
    logic [5:0]  load_len;
    logic        load_oneshot;
    logic [2:0]  led;
    logic [2:0]  busy;
    logic [2:0]  done;

    led_pattern_sequencer #(
        .CHANNELS        (NCH),
        .PAT_W           (32),
        .STEP_LOG2       (2),
        .DEFAULT_PATTERN (32'h0547_7715),
        .DEFAULT_LEN     (27)
    ) dut (
        .CLK_CPU      (CLK_CPU),
        .reset        (reset),
        .enable       (enable),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_channel (load_channel),
        .load_pattern (load_pattern),
        .load_len     (load_len),
        .load_oneshot (load_oneshot),
        .led          (led),
        .busy         (busy),
        .done         (done)
    );

    always #5 CLK_CPU = ~CLK_CPU;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_on  = 0;
    logic [31:0] sos = 32'h0547_7715;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: channel state 0=idle 1=run 2=done; pending loads kept in a queue of depth <= 1.
    typedef struct {
        int          ch;
        logic [31:0] pat;
        int          len;
        bit          os;
    } ld_t;

    ld_t         q[$];
    ld_t         ld;
    int          m_cnt;
    int          m_st  [NCH];
    int          m_pos [NCH];
    int          m_len [NCH];
    bit          m_os  [NCH];
    logic [31:0] m_pat [NCH];
    logic [2:0]  m_led;
    logic [2:0]  m_done;
    logic [2:0]  m_busy;
    bit          m_tick;
    bit          m_rdy;
    bit          m_free;
    int          m_apply;

    initial begin
        forever begin
            @(posedge CLK_CPU or posedge reset);
            if (reset) begin
                m_cnt = 0;
                q.delete();
                m_led  = '0;
                m_done = '0;
                for (int c = 0; c < NCH; c++) begin
                    m_st[c]  = 1;
                    m_pat[c] = 32'h0547_7715;
                    m_len[c] = 27;
                    m_os[c]  = 0;
                    m_pos[c] = 0;
                end
            end else begin
                m_tick  = enable && (m_cnt % 4 == 3);
                m_rdy   = (q.size() == 0);
                m_apply = -1;
                m_free  = 0;
                if (!m_rdy) begin
                    if (q[0].ch >= NCH) begin
                        m_free = 1;
                    end else if (m_st[q[0].ch] != 1 || m_tick) begin
                        m_apply = q[0].ch;
                        m_free  = 1;
                    end
                end
                for (int c = 0; c < NCH; c++) begin
                    m_led[c]  = (m_st[c] == 1) ? m_pat[c][m_pos[c]] : 1'b0;
                    m_done[c] = 1'b0;
                    if (c == m_apply) begin
                        m_pat[c] = q[0].pat;
                        m_len[c] = q[0].len;
                        m_os[c]  = q[0].os;
                        m_pos[c] = 0;
                        m_st[c]  = (q[0].len == 0) ? 0 : 1;
                    end else if (m_st[c] == 1 && m_tick) begin
                        if (m_pos[c] == m_len[c] - 1) begin
                            m_pos[c] = 0;
                            if (m_os[c]) begin
                                m_st[c]   = 2;
                                m_done[c] = 1'b1;
                            end
                        end else begin
                            m_pos[c] = m_pos[c] + 1;
                        end
                    end
                end
                if (m_free) void'(q.pop_front());
                if (load_valid && m_rdy) begin
                    ld.ch  = int'(load_channel);
                    ld.pat = load_pattern;
                    ld.len = (load_len > 6'd32) ? 32 : int'(load_len);
                    ld.os  = load_oneshot;
                    q.push_back(ld);
                end
                if (enable) m_cnt = m_cnt + 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK_CPU);
            if (cmp_on) begin
                for (int c = 0; c < NCH; c++) m_busy[c] = (m_st[c] == 1);
                chk("cmp_led",   32'(led),        32'(m_led));
                chk("cmp_busy",  32'(busy),       32'(m_busy));
                chk("cmp_done",  32'(done),       32'(m_done));
                chk("cmp_ready", 32'(load_ready), 32'(q.size() == 0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic adv(input int n);
        repeat (n) @(negedge CLK_CPU);
    endtask

    task automatic send(input int ch, input logic [31:0] pat, input int len, input bit os);
        int t = 0;
        load_channel = 2'(ch);
        load_pattern = pat;
        load_len     = 6'(len);
        load_oneshot = os;
        load_valid   = 1'b1;
        while (!load_ready && t < 200) begin
            adv(1);
            t++;
        end
        chk("send_accept", 32'(t < 200), 32'd1);
        adv(1);
        load_valid = 1'b0;
    endtask

    int wt;
    bit seen;

    initial begin
        enable       = 1'b1;
        load_valid   = 1'b0;
        load_channel = '0;
        load_pattern = '0;
        load_len     = '0;
        load_oneshot = 1'b0;
        #1 reset = 1'b1;
        #1 cmp_on = 1'b1;

        // Reset state
        @(negedge CLK_CPU);
        chk("rst_led",   32'(led),        32'd0);
        chk("rst_busy",  32'(busy),       32'd7);
        chk("rst_done",  32'(done),       32'd0);
        chk("rst_ready", 32'(load_ready), 32'd1);
        @(negedge CLK_CPU);
        reset = 1'b0;

        // T1: SOS, 4 clocks per bit, wraps after 27 bits
        for (int j = 0; j < 116; j++) begin
            adv(1);
            chk("t1_led", 32'(led), {29'd0, {3{sos[(j / 4) % 27]}}});
        end

        // T2: one-shot 101 on running ch0; the last edge was a tick
        load_channel = 2'd0;
        load_pattern = 32'b101;
        load_len     = 6'd3;
        load_oneshot = 1'b1;
        load_valid   = 1'b1;
        adv(1);
        load_valid = 1'b0;
        chk("t2_ready_held0", 32'(load_ready), 32'd0);
        adv(1);
        chk("t2_ready_held1", 32'(load_ready), 32'd0);
        adv(1);
        chk("t2_ready_held2", 32'(load_ready), 32'd0);
        adv(1);
        chk("t2_ready_free", 32'(load_ready), 32'd1);
        for (int k = 0; k < 12; k++) begin
            adv(1);
            chk("t2_led", 32'(led[0]), 32'((k < 4) || (k >= 8)));
        end
        chk("t2_done_pulse", 32'(done[0]), 32'd1);
        chk("t2_busy_off",   32'(busy[0]), 32'd0);
        adv(1);
        chk("t2_led_off",    32'(led[0]),  32'd0);
        chk("t2_done_clear", 32'(done[0]), 32'd0);

        // T3: len 0 stops ch0, then a len-2 load lands 1 cycle after accept
        send(0, 32'h0, 0, 1'b0);
        adv(1);
        chk("t3_idle_busy", 32'(busy[0]), 32'd0);
        chk("t3_idle_led",  32'(led[0]),  32'd0);
        send(0, 32'b10, 2, 1'b0);
        chk("t3_pending_busy",  32'(busy[0]),    32'd0);
        chk("t3_pending_ready", 32'(load_ready), 32'd0);
        adv(1);
        chk("t3_applied_busy",  32'(busy[0]),    32'd1);
        chk("t3_applied_ready", 32'(load_ready), 32'd1);
        adv(1);
        chk("t3_led_bit0", 32'(led[0]), 32'd0);
        adv(3);
        chk("t3_led_bit1", 32'(led[0]), 32'd1);

        // T4: back-to-back loads (second waits), len clamp, out-of-range channel
        send(1, 32'hF0F0_3C3C, 40, 1'b0);
        send(2, 32'h0000_0013, 5, 1'b1);
        send(3, 32'hFFFF_FFFF, 7, 1'b0);
        chk("t4_drop_held", 32'(load_ready), 32'd0);
        adv(1);
        chk("t4_drop_freed", 32'(load_ready), 32'd1);
        wt   = 0;
        seen = 1'b0;
        while (!seen && wt < 200) begin
            adv(1);
            seen = done[2];
            wt++;
        end
        chk("t4_ch2_done", 32'(seen), 32'd1);

        // T5: load lands on the final tick of a one-shot -> no done pulse
        send(0, 32'h1, 1, 1'b1);
        send(0, 32'h3, 2, 1'b0);
        for (int k = 0; k < 8; k++) begin
            adv(1);
            chk("t5_no_done", 32'(done[0]), 32'd0);
        end
        chk("t5_busy", 32'(busy[0]), 32'd1);

        // T6: freeze; idle-target load still drains, running-target load waits
        adv(2);
        enable = 1'b0;
        send(2, 32'h5, 3, 1'b0);
        adv(1);
        chk("t6_drain_busy",  32'(busy[2]),    32'd1);
        chk("t6_drain_ready", 32'(load_ready), 32'd1);
        send(1, 32'hFF, 8, 1'b0);
        adv(3);
        chk("t6_held_ready", 32'(load_ready), 32'd0);
        adv(40);
        chk("t6_still_held", 32'(load_ready), 32'd0);
        load_channel = 2'd0;
        load_valid   = 1'b1;
        adv(1);
        #2 reset = 1'b1;
        load_valid = 1'b0;
        @(negedge CLK_CPU);
        chk("t6_rst_led",   32'(led),        32'd0);
        chk("t6_rst_busy",  32'(busy),       32'd7);
        chk("t6_rst_done",  32'(done),       32'd0);
        chk("t6_rst_ready", 32'(load_ready), 32'd1);
        enable = 1'b1;
        reset  = 1'b0;
        for (int j = 0; j < 12; j++) begin
            adv(1);
            chk("t6_sos_led", 32'(led), {29'd0, {3{sos[j / 4]}}});
        end
        adv(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
